// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: measures the tick count from lights-out to
// the driver's button press, and flags jump starts and saturated timeouts.
module f1_reaction_timer #(
   parameter int unsigned TIME_WIDTH  = 16,
   parameter int unsigned LIGHT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic [LIGHT_WIDTH-1:0] lights,
   input  logic                   trigger,
   output logic [TIME_WIDTH-1:0]  time_out,
   output logic                   valid,
   output logic                   jump_start,
   output logic                   timeout,
   output logic                   busy
);

   localparam logic [TIME_WIDTH-1:0]  CNT_MAX    = {TIME_WIDTH{1'b1}};
   localparam logic [LIGHT_WIDTH-1:0] LIGHTS_ALL = {LIGHT_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      TIMING = 3'd2,
      DONE   = 3'd3,
      FAULT  = 3'd4
   } state_t;

   state_t                 state, state_n;
   logic [TIME_WIDTH-1:0]  count, count_n;
   logic [TIME_WIDTH-1:0]  time_out_n;
   logic                   valid_n;
   logic                   timeout_n;
   logic                   jump_start_n;
   logic                   busy_n;
   logic                   trigger_q;
   logic [LIGHT_WIDTH-1:0] lights_q;
   logic                   press;
   logic                   lights_out;

   // Rising edge of the button and the all-on to all-off light transition.
   assign press      = trigger && !trigger_q;
   assign lights_out = (lights_q == LIGHTS_ALL) && (lights == '0);

   // State, counter, edge-detect history and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         time_out   <= '0;
         valid      <= 1'b0;
         jump_start <= 1'b0;
         timeout    <= 1'b0;
         busy       <= 1'b0;
         trigger_q  <= 1'b0;
         lights_q   <= '0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         time_out   <= time_out_n;
         valid      <= valid_n;
         jump_start <= jump_start_n;
         timeout    <= timeout_n;
         busy       <= busy_n;
         trigger_q  <= trigger;
         lights_q   <= lights;
      end
   end

   // Next-state, counter and next-output decode.
   always_comb begin
      state_n    = state;
      count_n    = count;
      time_out_n = time_out;
      valid_n    = 1'b0;
      timeout_n  = timeout;

      case (state)
         IDLE: begin
            if (lights != '0) state_n = ARMED;
         end
         ARMED: begin
            // A press beats everything, even a simultaneous lights-out.
            if (press) begin
               state_n = FAULT;
            end else if (lights_out) begin
               state_n = TIMING;
               count_n = '0;
            end else if (lights == '0) begin
               state_n = IDLE;
            end
         end
         TIMING: begin
            // Result is the count before this edge; a coincident tick is dropped.
            if (press) begin
               state_n    = DONE;
               time_out_n = count;
               valid_n    = 1'b1;
               timeout_n  = 1'b0;
            end else if (tick) begin
               if (count == CNT_MAX) begin
                  state_n    = DONE;
                  time_out_n = CNT_MAX;
                  valid_n    = 1'b1;
                  timeout_n  = 1'b1;
               end else begin
                  count_n = count + TIME_WIDTH'(1);
               end
            end
         end
         DONE: begin
            if (lights != '0) state_n = ARMED;
         end
         FAULT: begin
            if ((lights == '0) && !trigger) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      jump_start_n = (state_n == FAULT);
      busy_n       = (state_n == ARMED) || (state_n == TIMING);
   end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed self-checking bench for f1_reaction_timer (16-bit and 4-bit timers).
module tb_f1_reaction_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic [7:0]  lights;
   logic        trigger;

   logic [15:0] time_out;
   logic        valid, jump_start, timeout, busy;
   logic [3:0]  time_out4;
   logic        valid4, jump_start4, timeout4, busy4;

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;
   int vcnt4  = 0;
   int b2b    = 0;
   logic vprev = 1'b0;
   int snap;

   always #5 clk = ~clk;

   f1_reaction_timer #(.TIME_WIDTH(16), .LIGHT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .tick(tick), .lights(lights), .trigger(trigger),
      .time_out(time_out), .valid(valid), .jump_start(jump_start),
      .timeout(timeout), .busy(busy)
   );

   f1_reaction_timer #(.TIME_WIDTH(4), .LIGHT_WIDTH(8)) dut4 (
      .clk(clk), .rst(rst), .tick(tick), .lights(lights), .trigger(trigger),
      .time_out(time_out4), .valid(valid4), .jump_start(jump_start4),
      .timeout(timeout4), .busy(busy4)
   );

   // Pulse counters and back-to-back valid detector.
   always @(posedge clk) begin
      if (valid) vcnt <= vcnt + 1;
      if (valid4) vcnt4 <= vcnt4 + 1;
      if (valid && vprev) b2b <= b2b + 1;
      vprev <= valid;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // 01,03,...,FF each for one cycle; optionally finish with 00.
   task automatic run_lights(input bit finish);
      lights = 8'h01;
      cyc();
      for (int i = 1; i < 8; i++) begin
         lights = (lights << 1) | 8'h01;
         cyc();
      end
      if (finish) begin
         lights = 8'h00;
         cyc();
      end
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         cyc();
      end
   endtask

   task automatic press_once();
      trigger = 1'b1;
      cyc();
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; lights = 8'h00; trigger = 1'b0;
      cyc();
      chk("rst_time_out", 32'(time_out), 0);
      chk("rst_flags", {28'd0, valid, jump_start, timeout, busy}, 0);

      // Reset held with active inputs: no activity.
      lights = 8'hFF; trigger = 1'b1; tick = 1'b1;
      repeat (3) cyc();
      chk("rst_hold_flags", {28'd0, valid, jump_start, timeout, busy}, 0);
      rst = 1'b0; lights = 8'h00; trigger = 1'b0; tick = 1'b0;
      cyc();
      chk("idle_busy", 32'(busy), 0);

      // Normal run: 37 ticks then press.
      lights = 8'h01;
      cyc();
      chk("armed_busy", 32'(busy), 1);
      run_lights(1'b1);
      chk("timing_busy", 32'(busy), 1);
      do_ticks(37);
      press_once();
      chk("norm_valid", 32'(valid), 1);
      chk("norm_time", 32'(time_out), 37);
      chk("norm_timeout", 32'(timeout), 0);
      chk("norm_busy", 32'(busy), 0);
      trigger = 1'b0;
      cyc();
      chk("norm_valid_drop", 32'(valid), 0);
      chk("norm_time_hold", 32'(time_out), 37);

      // Jump start while lights = 0F (DONE goes straight to ARMED).
      snap = vcnt;
      lights = 8'h01;
      cyc();
      chk("done_to_armed", 32'(busy), 1);
      lights = 8'h03; cyc();
      lights = 8'h07; cyc();
      lights = 8'h0F; cyc();
      press_once();
      chk("js_flag", 32'(jump_start), 1);
      chk("js_busy", 32'(busy), 0);
      lights = 8'h00;
      cyc();
      chk("js_hold_trig", 32'(jump_start), 1);
      trigger = 1'b0;
      cyc();
      chk("js_clear", 32'(jump_start), 0);
      chk("js_time_hold", 32'(time_out), 37);
      cyc();
      chk("js_no_valid", 32'(vcnt), 32'(snap));

      // Press coincident with FF->00: fault.
      run_lights(1'b0);
      lights = 8'h00; trigger = 1'b1;
      cyc();
      chk("sim_lo_fault", 32'(jump_start), 1);
      trigger = 1'b0;
      cyc();
      chk("sim_lo_idle", 32'(jump_start), 0);

      // Press coincident with tick after 5 ticks.
      run_lights(1'b1);
      do_ticks(5);
      tick = 1'b1; trigger = 1'b1;
      cyc();
      chk("sim_tick_valid", 32'(valid), 1);
      chk("sim_tick_time", 32'(time_out), 5);
      tick = 1'b0; trigger = 1'b0;
      cyc();

      // Abort: 07 -> 00 returns to idle with no output activity.
      snap = vcnt;
      lights = 8'h01; cyc();
      lights = 8'h03; cyc();
      lights = 8'h07; cyc();
      lights = 8'h00; cyc();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_js", 32'(jump_start), 0);
      cyc();
      chk("abort_no_valid", 32'(vcnt), 32'(snap));
      chk("abort_time_hold", 32'(time_out), 5);

      // Button held across lights-out: no press until release then press.
      trigger = 1'b1;
      cyc();
      run_lights(1'b1);
      chk("held_timing", 32'(busy), 1);
      chk("held_no_js", 32'(jump_start), 0);
      do_ticks(3);
      trigger = 1'b0;
      cyc();
      chk("held_release_busy", 32'(busy), 1);
      press_once();
      chk("held_valid", 32'(valid), 1);
      chk("held_time", 32'(time_out), 3);
      trigger = 1'b0;
      cyc();

      // Reset mid-TIMING at count 12.
      snap = vcnt;
      run_lights(1'b1);
      do_ticks(12);
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      cyc();
      chk("mid_rst_time", 32'(time_out), 0);
      chk("mid_rst_flags", {28'd0, valid, jump_start, timeout, busy}, 0);
      rst = 1'b0;
      cyc();
      chk("mid_rst_no_valid", 32'(vcnt), 32'(snap));
      run_lights(1'b1);
      do_ticks(2);
      press_once();
      chk("mid_rerun_time", 32'(time_out), 2);
      trigger = 1'b0;
      cyc();

      // Saturation on the 4-bit timer: 20 ticks, no press.
      rst = 1'b1; cyc(); rst = 1'b0; cyc();
      snap = vcnt4;
      run_lights(1'b1);
      do_ticks(15);
      chk("sat_not_yet", 32'(valid4), 0);
      chk("sat_busy_15", 32'(busy4), 1);
      tick = 1'b1;
      cyc();
      chk("sat_valid", 32'(valid4), 1);
      chk("sat_time", 32'(time_out4), 15);
      chk("sat_timeout", 32'(timeout4), 1);
      tick = 1'b0;
      cyc();
      do_ticks(4);
      chk("sat_one_pulse", 32'(vcnt4 - snap), 1);
      press_once();
      chk("sat_press_ignored", 32'(valid4), 0);
      chk("sat_time_hold", 32'(time_out4), 15);
      chk("sat_timeout_hold", 32'(timeout4), 1);
      chk("wide_time_20", 32'(time_out), 20);
      chk("wide_timeout", 32'(timeout), 0);
      trigger = 1'b0;
      cyc();
      cyc();
      chk("sat_total_pulses", 32'(vcnt4 - snap), 1);

      chk("valid_b2b", 32'(b2b), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
